shift_pipe_unit: RTL and testbench
==================================

Name: shift_pipe_unit

Overview:
- Parametrised, pipelined barrel shifter. Successor to the 8-bit combinational shift unit.
- Generalised data width. Adds rotate modes, a pass-through tag and an illegal-mode error flag.
- Takes one operation per cycle through valid/ready handshakes with full backpressure.
- Sits between the ALU issue stage and writeback. Results leave in order.

Parameters:
- WIDTH, 8, data width in bits. Must be a power of two and at least 4.
- TAG_W, 4, width of the opaque tag carried alongside each operation.
- SHW (localparam), log2(WIDTH), shift-amount width. Also the number of pipeline stages.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  an operation is presented.
- in_ready  output  1  the unit can accept the operation this cycle.
- data_in  input  WIDTH  operand.
- shift  input  SHW  shift amount, 0 to WIDTH-1.
- mode  input  3  000=SLL, 001=SRL, 010=SRA, 011=ROL, 100=ROR, 101-111 illegal.
- tag_in  input  TAG_W  operation tag.
- out_valid  output  1  a result is present.
- out_ready  input  1  downstream accepts the result.
- data_out  output  WIDTH  result.
- tag_out  output  TAG_W  tag_in of the same operation.
- out_err  output  1  the operation had an illegal mode.

Behaviour:
- Transfer rule: a transfer occurs on a rising edge where valid&&ready. Accept on the input side, retire on the output side.
- Pipeline structure:
  - SHW register stages, S0..S(SHW-1). Each stage holds valid, data, remaining shift bits, mode, tag and err.
  - Stage k conditionally shifts or rotates by 2^k, according to shift bit k and mode.
  - S0 captures the input with bit 0 already applied.
  - Output ports are driven directly from S(SHW-1).
- Per-mode semantics (sequential composition over all stages yields the total amount):
  - SLL: zero fill.
  - SRL: zero fill.
  - SRA: fill with data_in[WIDTH-1].
  - ROL/ROR: bits wrap around.
- shift=0: data_out=data_in, in every legal mode.
- Illegal mode:
  - Operation is still accepted and flows through with normal latency.
  - data_out=0, out_err=1.
  - out_err is 0 for all legal modes.
- Latency:
  - An operation accepted on edge E has out_valid=1 after edge E+SHW-1.
  - That is SHW edges counting E. WIDTH=8 gives 3 edges.
  - Holds when there is no backpressure.
- Advance rule:
  - Stage k loads when it is empty, or when stage k+1 loads in the same cycle.
  - The last stage loads when it is empty or out_ready=1.
  - in_ready = S0 loads. This is combinational from out_ready through the stage valids. There is no skid buffer.
- Throughput: 1 op/cycle while out_ready=1.
- Holding: with out_ready=0 the pipeline fills. At most SHW operations are in flight, then in_ready=0.
- Bubbles collapse: an empty stage always accepts from the stage before it.
- Output stability: while out_valid=1 and out_ready=0, data_out, tag_out and out_err hold stable.
- Simultaneous retire and accept, pipeline full: shift by one and accept the new op in the same cycle. No loss, no duplication.
- Ordering: results leave in acceptance order.
- Input-side rule: inputs are ignored when in_valid=0. The unit never samples inputs unless in_valid&&in_ready.
- Reset:
  - rst_n low, asynchronously: all stage valids = 0, data/tag/err = 0, so out_valid=0, data_out=0, tag_out=0, out_err=0.
  - Asserting reset mid-operation discards all in-flight ops.
  - in_ready=1 once reset is released.

Test Plan:
- WIDTH=8, data_in=0x96, shift=3, one op per mode (out_ready=1) -> outputs:
  - SLL 0xB0, SRL 0x12, SRA 0xF2, ROL 0xB4, ROR 0xD2.
  - Each appears 3 edges after acceptance, out_err=0, tag_out matches.
- 0x96 with shift=0 in all legal modes -> 0x96. mode=101, data 0xFF -> data_out=0x00, out_err=1, normal latency.
- Back-to-back stream:
  - Stimulus: 8 ops with tags 0..7, out_ready=1.
  - Required: 8 consecutive out_valid cycles, tags 0..7 in order, in_ready constantly 1.
- Backpressure:
  - Stimulus: out_ready=0 while 4 ops are offered.
  - Required: first 3 accepted, then in_ready=0. Output holds op 0 stable.
  - Then out_ready=1 for one cycle: op 0 retires, op 3 is accepted in the same edge, order preserved.
- Reset mid-flight:
  - Stimulus: 2 ops in pipeline, then pulse rst_n low between clock edges.
  - Required: out_valid drops immediately, no stale results after release, next op completes with normal latency.
- WIDTH=16, 0x8001, SRA by 15 -> 0xFFFF. ROR by 1 -> 0xC000. SLL by 15 -> 0x8000.

Source files
------------

// File: rtl/shift_pipe_unit.sv
// shift_pipe_unit: pipelined barrel shifter/rotator. Stage k applies a 2^k step; valid/ready on both sides.
// Ports: clk, rst_n (async, active low).
//        in_valid/in_ready accept {data_in, shift, mode, tag_in}.
//        out_valid/out_ready retire {data_out, tag_out, out_err} in acceptance order.
module shift_pipe_unit #(
    parameter int WIDTH = 8,
    parameter int TAG_W = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         data_in,
    input  logic [$clog2(WIDTH)-1:0] shift,
    input  logic [2:0]               mode,
    input  logic [TAG_W-1:0]         tag_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         data_out,
    output logic [TAG_W-1:0]         tag_out,
    output logic                     out_err
);
    localparam int SHW = $clog2(WIDTH);
    localparam logic [2:0] SLL = 3'd0, SRL = 3'd1, SRA = 3'd2, ROL = 3'd3, ROR = 3'd4;

    logic [SHW-1:0]   v, er, ld, s_v, s_er;
    logic [WIDTH-1:0] d    [SHW];
    logic [WIDTH-1:0] s_d  [SHW];
    logic [TAG_W-1:0] tg   [SHW];
    logic [TAG_W-1:0] s_tg [SHW];
    logic [SHW-1:0]   s_sh [SHW];
    logic [2:0]       s_md [SHW];
    // the last stage has no further shift step, so it keeps neither amount nor mode
    logic [SHW-1:0]   sh   [SHW-1];
    logic [2:0]       md   [SHW-1];

    // one conditional step of 2^k; illegal modes pass the (already zeroed) data through
    function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] x, input logic [2:0] m,
                                              input logic b, input int k);
        logic signed [WIDTH-1:0] sx;
        logic [WIDTH-1:0] sra;
        int n;
        n = 1 << k;
        sx = x;
        sra = sx >>> n;
        return !b ? x :
               m == SLL ? x << n :
               m == SRL ? x >> n :
               m == SRA ? sra :
               m == ROL ? (x << n) | (x >> (WIDTH - n)) :
               m == ROR ? (x >> n) | (x << (WIDTH - n)) : x;
    endfunction

    // stage k may load when out_ready is high or any stage from k to the end is empty
    always_comb begin
        ld = '0;
        for (int k = 0; k < SHW; k++)
            ld[k] = out_ready || !(&(v | SHW'((1 << k) - 1)));
    end

    always_comb begin
        s_v[0]  = in_valid;
        s_er[0] = mode > ROR;
        s_d[0]  = (mode > ROR) ? '0 : data_in;
        s_sh[0] = shift;
        s_md[0] = mode;
        s_tg[0] = tag_in;
        for (int k = 1; k < SHW; k++) begin
            s_v[k]  = v[k-1];
            s_er[k] = er[k-1];
            s_d[k]  = d[k-1];
            s_sh[k] = sh[k-1];
            s_md[k] = md[k-1];
            s_tg[k] = tg[k-1];
        end
    end

    // payload only moves with a valid op, so inputs are never sampled without a transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v  <= '0;
            er <= '0;
            for (int k = 0; k < SHW; k++) begin
                d[k]  <= '0;
                tg[k] <= '0;
            end
            for (int k = 0; k < SHW - 1; k++) begin
                sh[k] <= '0;
                md[k] <= '0;
            end
        end else begin
            for (int k = 0; k < SHW; k++) begin
                if (ld[k]) v[k] <= s_v[k];
                if (ld[k] && s_v[k]) begin
                    d[k]  <= step(s_d[k], s_md[k], s_sh[k][0], k);
                    tg[k] <= s_tg[k];
                    er[k] <= s_er[k];
                end
            end
            // remaining amount shifts right so the next stage always consumes bit 0
            for (int k = 0; k < SHW - 1; k++) begin
                if (ld[k] && s_v[k]) begin
                    sh[k] <= s_sh[k] >> 1;
                    md[k] <= s_md[k];
                end
            end
        end
    end

    assign in_ready  = ld[0];
    assign out_valid = v[SHW-1];
    assign data_out  = d[SHW-1];
    assign tag_out   = tg[SHW-1];
    assign out_err   = er[SHW-1];
endmodule

// File: tb/tb_shift_pipe_unit.sv
// tb_shift_pipe_unit: directed bench with a queue-based reference model for shift_pipe_unit
module tb_shift_pipe_unit;
    localparam int SHW = 3;

    logic clk = 0, rst_n = 0;
    always #5 clk = ~clk;

    logic       in_valid = 0, out_ready = 1, in_ready, out_valid, out_err;
    logic [7:0] data_in = 0, data_out;
    logic [2:0] shift = 0, mode = 0;
    logic [3:0] tag_in = 0, tag_out;

    logic        iv_w = 0, ir_w, ov_w, oe_w;
    logic [15:0] di_w = 0, do_w;
    logic [3:0]  sh_w = 0, ti_w = 0, to_w;
    logic [2:0]  md_w = 0;

    shift_pipe_unit #(.WIDTH(8), .TAG_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .data_in(data_in), .shift(shift), .mode(mode), .tag_in(tag_in),
        .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out),
        .tag_out(tag_out), .out_err(out_err));

    shift_pipe_unit #(.WIDTH(16), .TAG_W(4)) dut_w (
        .clk(clk), .rst_n(rst_n), .in_valid(iv_w), .in_ready(ir_w),
        .data_in(di_w), .shift(sh_w), .mode(md_w), .tag_in(ti_w),
        .out_valid(ov_w), .out_ready(1'b1), .data_out(do_w),
        .tag_out(to_w), .out_err(oe_w));

    int errors = 0, checks = 0, ecount = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, want);
        end
    endtask

    // reference: whole-amount arithmetic on the full operand; returns {err, data}
    function automatic logic [8:0] ref_op(input logic [7:0] x, input logic [2:0] s, input logic [2:0] m);
        logic [15:0] ext, rot;
        logic [7:0] r;
        ext = {{8{x[7]}}, x} >> s;
        rot = {x, x};
        case (m)
            3'd0: r = x << s;
            3'd1: r = x >> s;
            3'd2: r = ext[7:0];
            3'd3: begin rot = rot << s; r = rot[15:8]; end
            3'd4: begin rot = rot >> s; r = rot[7:0]; end
            default: return 9'h100;
        endcase
        return {1'b0, r};
    endfunction

    typedef struct { logic [8:0] r; logic [3:0] t; int acc; } op_t;
    op_t q[$];

    always @(negedge rst_n) q.delete();

    always @(posedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
            if (in_valid && in_ready) q.push_back('{ref_op(data_in, shift, mode), tag_in, ecount});
        end
        ecount++;
    end

    // the oldest op reaches the output SHW-1 edges after its accept edge and waits there
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst out_valid", out_valid, 0);
            chk("rst data_out", data_out, 0);
        end else begin
            logic ev;
            ev = q.size() > 0 && (ecount - q[0].acc) >= SHW;
            chk("mdl out_valid", out_valid, ev);
            chk("mdl in_ready", in_ready, out_ready || q.size() < SHW);
            if (ev) begin
                chk("mdl data_out", data_out, q[0].r[7:0]);
                chk("mdl out_err", out_err, q[0].r[8]);
                chk("mdl tag_out", tag_out, q[0].t);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic op8(input logic [7:0] d, input logic [2:0] s, input logic [2:0] m,
                       input logic [3:0] t, input logic [7:0] want, input logic want_e, input string name);
        int n;
        in_valid = 1; data_in = d; shift = s; mode = m; tag_in = t;
        chk({name, " in_ready"}, in_ready, 1);
        tick();
        in_valid = 0;
        n = 1;
        while (!out_valid && n < 10) begin tick(); n++; end
        chk({name, " latency"}, n, 3);
        chk({name, " data"}, data_out, want);
        chk({name, " err"}, out_err, want_e);
        chk({name, " tag"}, tag_out, t);
    endtask

    task automatic op16(input logic [15:0] d, input logic [3:0] s, input logic [2:0] m,
                        input logic [3:0] t, input logic [15:0] want, input string name);
        int n;
        iv_w = 1; di_w = d; sh_w = s; md_w = m; ti_w = t;
        tick();
        iv_w = 0;
        n = 1;
        while (!ov_w && n < 12) begin tick(); n++; end
        chk({name, " latency"}, n, 4);
        chk({name, " data"}, do_w, want);
        chk({name, " err"}, oe_w, 0);
        chk({name, " tag"}, to_w, t);
    endtask

    logic [7:0] w3 [5] = '{8'hB0, 8'h12, 8'hF2, 8'hB4, 8'hD2};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] seen[$];
        int first, last;
        #1;
        chk("reset out_valid", out_valid, 0);
        chk("reset data_out", data_out, 0);
        chk("reset tag_out", tag_out, 0);
        chk("reset out_err", out_err, 0);
        chk("reset w16 out_valid", ov_w, 0);
        @(posedge clk);
        #2 rst_n = 1;
        #1 chk("in_ready after reset", in_ready, 1);

        for (int m = 0; m < 5; m++) begin
            chk("model pin 0x96>>3", ref_op(8'h96, 3'd3, m[2:0]), {1'b0, w3[m]});
            op8(8'h96, 3'd3, m[2:0], m[3:0], w3[m], 1'b0, "shift3");
        end
        for (int m = 0; m < 5; m++) op8(8'h96, 3'd0, m[2:0], 4'(m + 5), 8'h96, 1'b0, "shift0");
        op8(8'hFF, 3'd3, 3'b101, 4'hA, 8'h00, 1'b1, "illegal101");
        op8(8'h5C, 3'd1, 3'b111, 4'hB, 8'h00, 1'b1, "illegal111");

        first = -1; last = -1;
        for (int c = 0; c < 14; c++) begin
            if (c < 8) begin
                in_valid = 1; data_in = 8'h96 ^ 8'(c * 37); shift = 3'(c);
                mode = 3'(c % 5); tag_in = 4'(c);
                chk("stream in_ready", in_ready, 1);
            end else in_valid = 0;
            tick();
            if (out_valid) begin
                seen.push_back(tag_out);
                if (first < 0) first = c;
                last = c;
            end
        end
        chk("stream count", seen.size(), 8);
        chk("stream consecutive", last - first, 7);
        for (int i = 0; i < seen.size(); i++) chk("stream order", seen[i], i);

        out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1; data_in = 8'h5A + 8'(i); shift = 3'(i + 1); mode = 3'(i); tag_in = 4'(8 + i);
            chk("bp accept in_ready", in_ready, 1);
            tick();
        end
        in_valid = 1; data_in = 8'hC3; shift = 3'd7; mode = 3'd4; tag_in = 4'd11;
        #1;
        chk("bp full in_ready", in_ready, 0);
        chk("bp out_valid", out_valid, 1);
        chk("bp head tag", tag_out, 8);
        chk("bp head data", data_out, 8'hB4);
        tick(); tick();
        chk("bp hold in_ready", in_ready, 0);
        chk("bp hold tag", tag_out, 8);
        chk("bp hold data", data_out, 8'hB4);
        out_ready = 1;
        #1 chk("bp release in_ready", in_ready, 1);
        tick();
        out_ready = 0; in_valid = 0;
        #1;
        chk("bp after retire tag", tag_out, 9);
        chk("bp refilled in_ready", in_ready, 0);
        out_ready = 1;
        seen.delete();
        for (int c = 0; c < 6; c++) begin
            if (out_valid) seen.push_back(tag_out);
            tick();
        end
        chk("bp drain count", seen.size(), 3);
        for (int i = 0; i < seen.size(); i++) chk("bp drain order", seen[i], 9 + i);

        for (int i = 0; i < 3; i++) begin
            in_valid = 1; data_in = 8'h33 + 8'(i); shift = 3'd2; mode = 3'd3; tag_in = 4'(12 + i);
            tick();
        end
        in_valid = 0;
        chk("pre-reset out_valid", out_valid, 1);
        rst_n = 0;
        #1;
        chk("async reset out_valid", out_valid, 0);
        chk("async reset data_out", data_out, 0);
        chk("async reset tag_out", tag_out, 0);
        chk("async reset out_err", out_err, 0);
        #1 rst_n = 1;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("no stale after reset", out_valid, 0);
        end
        op8(8'h81, 3'd2, 3'd4, 4'hF, 8'h60, 1'b0, "post-reset ror");

        op16(16'h8001, 4'd15, 3'd2, 4'h1, 16'hFFFF, "w16 sra15");
        op16(16'h8001, 4'd1, 3'd4, 4'h2, 16'hC000, "w16 ror1");
        op16(16'h8001, 4'd15, 3'd0, 4'h3, 16'h8000, "w16 sll15");

        tick(); tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
